// File: rtl/cpu_ctrl_pkg.sv
// Shared control-flow encodings for the PC redirect path.
// Op codes, branch conditions, flag bit positions and FSM states.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        CF_NONE = 3'd0,
        CF_BR   = 3'd1,
        CF_JMP  = 3'd2,
        CF_CALL = 3'd3,
        CF_RET  = 3'd4,
        CF_JR   = 3'd5
    } cf_op_e;

    typedef enum logic [2:0] {
        C_NEQ = 3'd0,
        C_EQ  = 3'd1,
        C_GT  = 3'd2,
        C_LT  = 3'd3,
        C_GTE = 3'd4,
        C_LTE = 3'd5,
        C_OVF = 3'd6,
        C_UNC = 3'd7
    } cond_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } pc_state_e;

    // Evaluate a branch condition against a {Z,N,V} flag vector.
    function automatic logic cond_met(
        input logic [2:0] c,
        input logic [2:0] f
    );
        logic z;
        logic n;
        logic v;
        z = f[FLAG_Z];
        n = f[FLAG_N];
        v = f[FLAG_V];
        cond_met = 1'b1;
        case (c)
            C_NEQ:   cond_met = !z;
            C_EQ:    cond_met = z;
            C_GT:    cond_met = !z && !n;
            C_LT:    cond_met = n;
            C_GTE:   cond_met = !n;
            C_LTE:   cond_met = z || n;
            C_OVF:   cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack; a full push overwrites the oldest entry.
// Popping an empty stack yields 0. Errors are single-cycle pulses.
module return_addr_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              overflow,
    output logic              underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]     r_ptr;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     w_top;
    logic              w_full;
    logic              w_empty;

    assign w_top     = r_ptr - PW'(1);
    assign w_full    = (r_cnt == CW'(RAS_DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign dout      = w_empty ? '0 : r_mem[w_top];
    assign overflow  = push && w_full;
    assign underflow = pop && !push && w_empty;

    // Pointer/count update; pointer wraps naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + PW'(1);
            if (!w_full) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (pop && !w_empty) begin
            r_ptr <= w_top;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Entry storage; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_ptr] <= din;
        end
    end

endmodule

// File: rtl/pc_control_unit.sv
// Fetch-redirect producer: flags, branch evaluation, RAS and hold FSM.
// A registered redirect is held until fetch consumes it (hazard low).
module pc_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [2:0]        cond,
    input  logic [ADDR_W-1:0] pc_plus1,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              flags_we,
    input  logic [2:0]        flags_in,
    input  logic              hazard,
    output logic              PC_src,
    output logic [ADDR_W-1:0] PC_control,
    output logic              flush,
    output logic              ras_err
);

    pc_state_e         r_state;
    pc_state_e         w_state_nxt;
    logic [2:0]        r_flags;
    logic [ADDR_W-1:0] r_target;
    logic              r_ras_err;

    logic              w_accept;
    logic              w_redir;
    logic [ADDR_W-1:0] w_target;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_ras_dout;
    logic              w_ovf;
    logic              w_unf;

    assign w_accept = (r_state == ST_IDLE) && op_valid;
    assign w_push   = w_accept && (op == CF_CALL);
    assign w_pop    = w_accept && (op == CF_RET);

    return_addr_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .pop      (w_pop),
        .din      (pc_plus1),
        .dout     (w_ras_dout),
        .overflow (w_ovf),
        .underflow(w_unf)
    );

    // Target select; branches use the registered (old) flags.
    always_comb begin
        w_redir  = 1'b0;
        w_target = '0;
        case (op)
            CF_BR: begin
                w_redir  = cond_met(cond, r_flags);
                w_target = pc_plus1 + imm;
            end
            CF_JMP, CF_CALL: begin
                w_redir  = 1'b1;
                w_target = imm;
            end
            CF_RET: begin
                w_redir  = 1'b1;
                w_target = w_ras_dout;
            end
            CF_JR: begin
                w_redir  = 1'b1;
                w_target = reg_target;
            end
            default: begin
                w_redir  = 1'b0;
                w_target = '0;
            end
        endcase
    end

    // Next state: enter on an accepted redirect, leave when fetch takes it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_redir) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (!hazard) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, held target, flags and sticky stack error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_target  <= '0;
            r_flags   <= '0;
            r_ras_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && w_redir) begin
                r_target <= w_target;
            end
            if (flags_we) begin
                r_flags <= flags_in;
            end
            if (w_ovf || w_unf) begin
                r_ras_err <= 1'b1;
            end
        end
    end

    assign PC_src     = (r_state == ST_REDIRECT);
    assign PC_control = r_target;
    assign flush      = PC_src && !hazard;
    assign ras_err    = r_ras_err;

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed test-plan scenarios plus randomized traffic against a
// transaction-level model (pending redirect + queue-based RAS).
module tb_pc_control_unit;
    import cpu_ctrl_pkg::*;

    localparam int AW = 32;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid;
    logic [2:0]    op;
    logic [2:0]    cond;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] imm;
    logic [AW-1:0] reg_target;
    logic          flags_we;
    logic [2:0]    flags_in;
    logic          hazard;
    logic          PC_src;
    logic [AW-1:0] PC_control;
    logic          flush;
    logic          ras_err;

    always #5 clk = ~clk;

    pc_control_unit #(.ADDR_W(AW), .RAS_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op        (op),
        .cond      (cond),
        .pc_plus1  (pc_plus1),
        .imm       (imm),
        .reg_target(reg_target),
        .flags_we  (flags_we),
        .flags_in  (flags_in),
        .hazard    (hazard),
        .PC_src    (PC_src),
        .PC_control(PC_control),
        .flush     (flush),
        .ras_err   (ras_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    bit            m_pend;
    bit            m_err;
    logic [AW-1:0] m_tgt;
    logic [2:0]    m_flags;
    logic [AW-1:0] m_ras[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit taken(logic [2:0] c, logic [2:0] f);
        bit z;
        bit n;
        bit v;
        z = f[2];
        n = f[1];
        v = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return !n;
            3'd5:    return z || n;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_edge();
        if (!rst) begin
            m_pend  = 0;
            m_err   = 0;
            m_tgt   = '0;
            m_flags = '0;
            m_ras.delete();
            return;
        end
        if (m_pend) begin
            if (!hazard) m_pend = 0;
        end else if (op_valid) begin
            case (op)
                3'd1: if (taken(cond, m_flags)) begin
                    m_pend = 1;
                    m_tgt  = pc_plus1 + imm;
                end
                3'd2: begin
                    m_pend = 1;
                    m_tgt  = imm;
                end
                3'd3: begin
                    m_pend = 1;
                    m_tgt  = imm;
                    m_ras.push_back(pc_plus1);
                    if (m_ras.size() > D) begin
                        void'(m_ras.pop_front());
                        m_err = 1;
                    end
                end
                3'd4: begin
                    m_pend = 1;
                    if (m_ras.size() == 0) begin
                        m_tgt = '0;
                        m_err = 1;
                    end else begin
                        m_tgt = m_ras.pop_back();
                    end
                end
                3'd5: begin
                    m_pend = 1;
                    m_tgt  = reg_target;
                end
                default: ;
            endcase
        end
        if (flags_we) m_flags = flags_in;
    endtask

    task automatic tick();
        #1;
        check("pc_src", {31'd0, PC_src}, {31'd0, m_pend});
        check("flush", {31'd0, flush}, {31'd0, m_pend && !hazard});
        check("ras_err", {31'd0, ras_err}, {31'd0, m_err});
        if (m_pend) check("pc_control", PC_control, m_tgt);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(bit v, logic [2:0] o, logic [2:0] c,
                         logic [31:0] p, logic [31:0] i, bit hz);
        op_valid = v;
        op       = o;
        cond     = c;
        pc_plus1 = p;
        imm      = i;
        hazard   = hz;
        tick();
    endtask

    task automatic idle();
        drive(0, 3'd0, 3'd0, 32'd0, 32'd0, 0);
    endtask

    task automatic do_reset();
        rst = 0;
        idle();
        rst = 1;
    endtask

    initial begin
        rst        = 0;
        op_valid   = 0;
        op         = 0;
        cond       = 0;
        pc_plus1   = 0;
        imm        = 0;
        reg_target = 0;
        flags_we   = 0;
        flags_in   = 0;
        hazard     = 0;
        @(posedge clk);
        model_edge();
        #1;
        rst = 1;

        check("rst_pc_src", {31'd0, PC_src}, 32'd0);
        check("rst_pc_control", PC_control, 32'd0);
        check("rst_ras_err", {31'd0, ras_err}, 32'd0);

        // taken branch
        flags_we = 1;
        flags_in = 3'b100;
        idle();
        flags_we = 0;
        drive(1, 3'd1, 3'd1, 32'h10, 32'hFFFF_FFFC, 0);
        check("br_src", {31'd0, PC_src}, 32'd1);
        check("br_target", PC_control, 32'h0C);
        idle();
        check("br_drop", {31'd0, PC_src}, 32'd0);

        // not-taken branch
        flags_we = 1;
        flags_in = 3'b000;
        idle();
        flags_we = 0;
        drive(1, 3'd1, 3'd1, 32'h10, 32'h8, 0);
        check("nt_src", {31'd0, PC_src}, 32'd0);
        idle();

        // hazard hold with a wrong-path op presented
        drive(1, 3'd2, 3'd7, 32'h0, 32'h40, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 3'd2, 3'd7, 32'h0, 32'h99, 1);
            check("hold_target", PC_control, 32'h40);
        end
        drive(1, 3'd2, 3'd7, 32'h0, 32'h99, 0);
        check("hold_drop", {31'd0, PC_src}, 32'd0);
        idle();

        // call/return nesting
        drive(1, 3'd3, 3'd0, 32'h5, 32'h100, 0);
        check("call1", PC_control, 32'h100);
        idle();
        drive(1, 3'd3, 3'd0, 32'h101, 32'h200, 0);
        check("call2", PC_control, 32'h200);
        idle();
        drive(1, 3'd4, 3'd0, 32'h0, 32'h0, 0);
        check("ret1", PC_control, 32'h101);
        idle();
        drive(1, 3'd4, 3'd0, 32'h0, 32'h0, 0);
        check("ret2", PC_control, 32'h5);
        idle();
        check("nest_err", {31'd0, ras_err}, 32'd0);

        // RAS overflow / underflow
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(1, 3'd3, 3'd0, 32'h1000 + k, 32'h2000 + k, 0);
            idle();
        end
        check("ovf_err", {31'd0, ras_err}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            drive(1, 3'd4, 3'd0, 32'h0, 32'h0, 0);
            check("lifo_ret", PC_control, (k < 8) ? 32'h1008 - k : 32'h0);
            idle();
        end

        // reset mid-redirect
        do_reset();
        drive(1, 3'd2, 3'd0, 32'h0, 32'h77, 0);
        drive(0, 3'd0, 3'd0, 32'h0, 32'h0, 1);
        rst = 0;
        drive(0, 3'd0, 3'd0, 32'h0, 32'h0, 1);
        rst = 1;
        check("rr_src", {31'd0, PC_src}, 32'd0);
        check("rr_ctrl", PC_control, 32'd0);
        check("rr_flush", {31'd0, flush}, 32'd0);
        drive(1, 3'd4, 3'd0, 32'h0, 32'h0, 0);
        check("rr_ret", PC_control, 32'd0);
        check("rr_err", {31'd0, ras_err}, 32'd1);
        idle();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 199) != 0);
            flags_we   = $urandom_range(0, 2) == 0;
            flags_in   = 3'($urandom_range(0, 7));
            reg_target = $urandom;
            drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom_range(0, 9) < 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_control_unit.md
# pc_control_unit

Decode/execute-side producer of the fetch redirect. Consumes resolved control-flow instructions, evaluates branch conditions against registered ALU flags, maintains a return-address stack for call/return, and drives the `PC_src`/`PC_control` redirect into the fetch unit. It holds the redirect across hazard stalls until fetch has taken it, and flushes wrong-path instructions.

## Interface
- `ADDR_W`, 32: PC/target width.
- `RAS_DEPTH`, 8: return-address stack entries; must be a power of 2, ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-low (0 = reset).
- `op_valid`  in  1: a control-flow op is presented this cycle.
- `op`  in  3: `CF_NONE`=0, `CF_BR`=1, `CF_JMP`=2, `CF_CALL`=3, `CF_RET`=4, `CF_JR`=5; codes 6–7 are treated as `CF_NONE`.
- `cond`  in  3: branch condition: `NEQ`=0, `EQ`=1, `GT`=2, `LT`=3, `GTE`=4, `LTE`=5, `OVF`=6, `UNC`=7.
- `pc_plus1`  in  ADDR_W: PC of the op + 1 (fall-through / return address).
- `imm`  in  ADDR_W: sign-extended branch offset (`CF_BR`) or absolute target (`CF_JMP`, `CF_CALL`).
- `reg_target`  in  ADDR_W: register target for `CF_JR`.
- `flags_we`  in  1: ALU writes flags this cycle.
- `flags_in`  in  3: {Z, N, V} from ALU.
- `hazard`  in  1: fetch stalled (data or PC hazard); the fetch PC does not advance.
- `PC_src`  out  1: redirect valid.
- `PC_control`  out  ADDR_W: redirect target.
- `flush`  out  1: squash the IF/ID stage this cycle.
- `ras_err`  out  1: sticky flag for stack overflow or underflow.

## Operation
- Flags register {Z,N,V} loads `flags_in` when `flags_we` = 1; it resets to 0.
- Branch conditions are evaluated on the registered flags, not `flags_in`:
  - `NEQ` = !Z
  - `EQ` = Z
  - `GT` = !Z & !N
  - `LT` = N
  - `GTE` = !N
  - `LTE` = Z | N
  - `OVF` = V
  - `UNC` = 1
- Target by op:
  - `CF_BR` taken: `pc_plus1 + imm`, modulo 2^ADDR_W. A not-taken branch makes no redirect.
  - `CF_JMP`: `imm`.
  - `CF_CALL`: `imm`, and pushes `pc_plus1` onto the RAS.
  - `CF_RET`: pops the RAS and uses the popped value.
  - `CF_JR`: `reg_target`.
- RAS behaviour:
  - Circular buffer with pointer and count.
  - Push when full overwrites the oldest entry (wraps) and sets `ras_err`.
  - Pop when empty returns 0 and sets `ras_err`.
- State machine: `IDLE`, `REDIRECT`.
  - `IDLE` with an accepted op that redirects: register the target, go to `REDIRECT`.
  - `REDIRECT` with `hazard` = 0: fetch consumes the redirect at this edge; go to `IDLE`.
  - `REDIRECT` with `hazard` = 1: stay; `PC_control` is held stable.
- `op_valid` is accepted only in `IDLE`. In `REDIRECT`, the presented op is wrong-path and is ignored: no RAS push/pop, no redirect.
- `flush` = `PC_src & !hazard`, i.e. asserted in the cycle fetch consumes the redirect.
- `ras_err` is cleared only by reset.

## Timing
- Reset values:
  - `PC_src` = 0, `PC_control` = 0, `flush` = 0, `ras_err` = 0.
  - RAS count = 0, pointer = 0, state = `IDLE`.
- Latency: op accepted at edge N → `PC_src` = 1 during cycle N+1.
- Hold rule: `PC_src`/`PC_control` stay asserted until the first edge at which `hazard` = 0, inclusive; `PC_src` drops the following cycle.
- Back-to-back: the earliest next accepted op is the cycle after `PC_src` drops.
- Same-cycle RAS updates:
  - A push/pop occurs at the accepting edge.
  - `CF_CALL` followed by `CF_RET` two cycles later returns the pushed address.
- `flags_we` in the same cycle as a `CF_BR`: the branch uses the old flags; the new flags are visible from the next cycle.
- Reset in `REDIRECT`: the redirect is abandoned, and `PC_src` = 0 the next cycle.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - `CF_*` op codes
  - condition codes
  - flag bit indices (Z=2, N=1, V=0)
  - state encoding
- Sub-module `return_addr_stack` (params `ADDR_W`, `RAS_DEPTH`):
  - inputs `push`, `pop`, `din`
  - outputs `dout`, `overflow`, `underflow`
- The top module holds the flags register, condition evaluation, target mux, and FSM.

## Test plan
- Taken branch:
  - Stimulus: flags Z=1 loaded; `CF_BR`/`EQ`, `pc_plus1`=0x10, `imm`=0xFFFF_FFFC.
  - Required: next cycle `PC_src`=1, `PC_control`=0x0C, `flush`=1; `PC_src`=0 one cycle later.
- Not-taken branch:
  - Stimulus: Z=0, `CF_BR`/`EQ`.
  - Required: `PC_src` stays 0; no flush.
- Hazard hold:
  - Stimulus: `CF_JMP` with `imm`=0x40; `hazard`=1 for 3 cycles after acceptance.
  - Required: `PC_src`=1 and `PC_control`=0x40 for 4 cycles; `flush`=1 only in the 4th; an op presented during the hold is ignored.
- Call/return nesting:
  - Stimulus: CALL from `pc_plus1`=0x5 to 0x100, CALL from 0x101 to 0x200, RET, RET.
  - Required: redirects 0x100, 0x200, 0x101, 0x5; `ras_err`=0.
- RAS limits (`RAS_DEPTH`=8):
  - Stimulus: 9 CALLs, then 9 RETs.
  - Required: `ras_err`=1 after the 9th CALL; the first 8 RETs return the last 8 pushed addresses in LIFO order; the 9th RET targets 0.
- Reset mid-redirect:
  - Stimulus: `rst`=0 while in `REDIRECT` under `hazard`.
  - Required: all outputs 0 the next cycle; a RET immediately after reset targets 0 and sets `ras_err`.
